// File: rtl/fsk_tx_ctrl.sv
// FSK transmit framing controller: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define FSK_TX_PARITY_EN to insert the even-parity slot between the data bits and the stop bit.
module fsk_tx_ctrl #(
  parameter int   BIT_CYCLES = 16,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       word_valid,
  input  logic [7:0] word,
  output logic       word_ready,
  output logic       bit_out,
  output logic       freq_sel,
  output logic       busy,
  output logic       done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

`ifdef FSK_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [CW-1:0] cyc_cnt, cyc_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          bit_nxt;
  logic          cyc_last;
  logic          accept;

  assign cyc_last   = (cyc_cnt == CYC_LAST);
  assign word_ready = rst && tx_en && ((state == IDLE) || ((state == STOP) && cyc_last));
  assign accept     = word_valid && word_ready;
  assign done       = (state == STOP) && cyc_last;
  assign busy       = (state != IDLE);
  assign freq_sel   = bit_out;

  // The shift register rotates rather than shifts, so it holds the original
  // word again after the eighth bit and its XOR reduction is the parity bit.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    cyc_cnt_nxt = cyc_last ? '0 : cyc_cnt + CW'(1);
    case (state)
      IDLE: begin
        cyc_cnt_nxt = '0;
        if (accept) begin
          state_nxt = START;
          shreg_nxt = word;
        end
      end
      START: begin
        if (cyc_last) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (cyc_last) begin
          shreg_nxt   = {shreg[0], shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef FSK_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef FSK_TX_PARITY_EN
      PARITY: begin
        if (cyc_last) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (cyc_last) begin
          if (accept) begin
            state_nxt = START;
            shreg_nxt = word;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line level is a function of the state being entered, keeping bit_out registered.
    bit_nxt = IDLE_LEVEL;
    case (state_nxt)
      IDLE:   bit_nxt = IDLE_LEVEL;
      START:  bit_nxt = 1'b0;
      DATA:   bit_nxt = shreg_nxt[0];
`ifdef FSK_TX_PARITY_EN
      PARITY: bit_nxt = ^shreg_nxt;
`endif
      STOP:   bit_nxt = 1'b1;
      default: bit_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      shreg   <= '0;
      bit_out <= IDLE_LEVEL;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      cyc_cnt <= cyc_cnt_nxt;
      shreg   <= shreg_nxt;
      bit_out <= bit_nxt;
    end
  end

endmodule

// File: doc/fsk_tx_ctrl.md
FSK_TX_CTRL -- requirements
Module: fsk_tx_ctrl

Interface
REQ-001 SHALL provide parameter BIT_CYCLES, default 16, clock cycles per transmitted bit (legal range 2..65535).
REQ-002 SHALL provide parameter IDLE_LEVEL, default 1, line level (mark) driven on bit_out when no frame is in progress.
REQ-003 SHALL provide port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port tx_en  input  1  permits acceptance of new words; does not affect a frame already in progress.
REQ-006 SHALL provide port word_valid  input  1  word source offers a word.
REQ-007 SHALL provide port word  input  8  word to transmit, sampled only on acceptance.
REQ-008 SHALL provide port word_ready  output  1  controller can accept a word this cycle.
REQ-009 SHALL provide port bit_out  output  1  serial line bit to the FSK modulator; registered.
REQ-010 SHALL provide port freq_sel  output  1  carrier select to the modulator; equals bit_out in the same cycle (1 = mark, 0 = space).
REQ-011 SHALL provide port busy  output  1  high while state is not IDLE.
REQ-012 SHALL provide port done  output  1  one-cycle pulse marking the final cycle of a frame.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP; state, bit counter (3 bits), cycle counter ($clog2(BIT_CYCLES) bits) and shift register all registered.
REQ-014 SHALL assert word_ready = tx_en in IDLE and = tx_en in the last cycle of STOP; otherwise 0.
REQ-015 SHALL accept a word when word_valid and word_ready are both 1 on a rising edge: capture word into the shift register and enter START on that edge.
REQ-016 SHALL drive bit_out = 0 for exactly BIT_CYCLES cycles in START, with the first 0 visible in the cycle after acceptance (latency 1).
REQ-017 SHALL transmit the 8 data bits LSB first in DATA, each held exactly BIT_CYCLES cycles; bit counter wraps 7 -> exit to PARITY or STOP.
REQ-018 SHALL drive bit_out = 1 for exactly BIT_CYCLES cycles in STOP, and pulse done in its last cycle.
REQ-019 SHALL, on acceptance in the last STOP cycle, go directly to START (back-to-back frames, zero gap); otherwise go to IDLE.
REQ-020 SHALL drive bit_out = IDLE_LEVEL in IDLE.
REQ-021 SHALL ignore word_valid and word while not word_ready; no capture, no state change.
REQ-022 SHALL complete an in-progress frame when tx_en falls mid-frame, then remain in IDLE until tx_en returns.
REQ-023 SHALL make the frame length exactly 10*BIT_CYCLES cycles (11*BIT_CYCLES with parity).

Reset
REQ-024 SHALL, on rst low, asynchronously force state IDLE, counters 0, shift register 0, bit_out = IDLE_LEVEL, freq_sel = IDLE_LEVEL, word_ready 0, busy 0, done 0.
REQ-025 SHALL abort any frame in progress on reset with no done pulse; first acceptance possible on the first rising edge after rst deasserts with tx_en high.

Configuration
REQ-026 SHALL, when macro FSK_TX_PARITY_EN is defined, insert PARITY state after DATA driving the even-parity bit (XOR of 8 data bits) for BIT_CYCLES cycles.
REQ-027 SHALL, when FSK_TX_PARITY_EN is undefined, omit PARITY entirely: DATA goes directly to STOP.

Verification
REQ-028 SHALL cover: BIT_CYCLES=4, no parity, word 0x01 accepted cycle 0 -> bit_out per 4-cycle slot 0,1,0,0,0,0,0,0,0,1; done in cycle 40; IDLE cycle 41.
REQ-029 SHALL cover: BIT_CYCLES=4, FSK_TX_PARITY_EN defined, word 0x07 -> slots 0,1,1,1,0,0,0,0,0,1,1 (parity 1); frame 44 cycles; done in cycle 44.
REQ-030 SHALL cover: word_valid held high, words 0x01 then 0x80 -> second acceptance in done cycle, START begins next cycle, no idle gap; freq_sel tracks bit_out every cycle.
REQ-031 SHALL cover: tx_en dropped in cycle 10 of a frame -> frame finishes intact, word_ready stays 0 afterwards until tx_en high again.
REQ-032 SHALL cover: rst asserted mid-DATA -> bit_out = 1, busy 0, no done pulse, immediately (asynchronously); new word 0x55 after release transmits correctly.
